// File: rtl/mysystem_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_sysid_checker
// Purpose  : Reads the two words of a sysid control slave over Avalon-MM
//            (word 0 = system ID, word 1 = build timestamp), compares them
//            with the values this build expects and holds the verdict.
//            Optionally runs one check by itself after reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_i            in   1   sole clock, rising edge
//   reset_n_i          in   1   synchronous active-low reset
//   start_i            in   1   single-cycle check request (ignored while busy)
//   m_address_o        out  1   Avalon word address: 0 = ID, 1 = timestamp
//   m_read_o           out  1   Avalon read strobe
//   m_readdata_i       in   32  read data, valid when read && !waitrequest
//   m_waitrequest_i    in   1   slave stall
//   busy_o             out  1   check in progress (RD_ID, RD_TS, CHECK)
//   done_o             out  1   finished result held
//   id_match_o         out  1   captured ID equals EXPECTED_ID
//   ts_match_o         out  1   captured timestamp equals EXPECTED_TS
//   timeout_o          out  1   last check aborted by a stall timeout
//   captured_id_o      out  32  raw word 0 as read
//   captured_ts_o      out  32  raw word 1 as read
// ============================================================================
module mysystem_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h8765_4321,
  parameter logic [31:0] EXPECTED_TS    = 32'd1766722860,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  output logic        m_address_o,
  output logic        m_read_o,
  input  logic [31:0] m_readdata_i,
  input  logic        m_waitrequest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        id_match_o,
  output logic        ts_match_o,
  output logic        timeout_o,
  output logic [31:0] captured_id_o,
  output logic [31:0] captured_ts_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Stall count at which the read is abandoned: the TIMEOUT_CYCLES-th
  // consecutive stalled cycle has count TIMEOUT_CYCLES-1.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        m_address_q;
  logic        m_read_q;
  logic        busy_q;
  logic        done_q;
  logic        id_match_q;
  logic        ts_match_q;
  logic        timeout_q;
  logic [31:0] captured_id_q;
  logic [31:0] captured_ts_q;
  logic [15:0] stall_cnt_q;
  logic        auto_fired_q;

  // Combinational helpers feeding the registered FSM.
  logic        launch_d;
  logic        auto_launch_d;
  logic        stall_expired_d;
  logic        id_equal_d;
  logic        ts_equal_d;

  // The one-shot automatic check behaves exactly like a start pulse seen in
  // IDLE; it is only armed again by reset.
  assign auto_launch_d   = AUTO_START && !auto_fired_q;
  assign launch_d        = start_i || auto_launch_d;
  assign stall_expired_d = m_waitrequest_i && (stall_cnt_q == STALL_LAST);
  assign id_equal_d      = (captured_id_q == EXPECTED_ID);
  assign ts_equal_d      = (captured_ts_q == EXPECTED_TS);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      m_address_q   <= 1'b0;
      m_read_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_q     <= 1'b0;
      captured_id_q <= 32'd0;
      captured_ts_q <= 32'd0;
      stall_cnt_q   <= 16'd0;
      auto_fired_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (launch_d) begin
            state_q     <= S_RD_ID;
            m_read_q    <= 1'b1;
            m_address_q <= 1'b0;
            busy_q      <= 1'b1;
            stall_cnt_q <= 16'd0;
            if (auto_launch_d) begin
              auto_fired_q <= 1'b1;
            end
          end
        end

        S_RD_ID: begin
          if (!m_waitrequest_i) begin
            captured_id_q <= m_readdata_i;
            state_q       <= S_RD_TS;
            m_address_q   <= 1'b1;
            stall_cnt_q   <= 16'd0;
          end else if (stall_expired_d) begin
            // Abort: strobe drops in the DONE cycle, verdict forced false.
            state_q    <= S_DONE;
            m_read_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
          end
        end

        S_RD_TS: begin
          if (!m_waitrequest_i) begin
            captured_ts_q <= m_readdata_i;
            state_q       <= S_CHECK;
            m_read_q      <= 1'b0;
            stall_cnt_q   <= 16'd0;
          end else if (stall_expired_d) begin
            state_q    <= S_DONE;
            m_read_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
          end
        end

        S_CHECK: begin
          id_match_q <= id_equal_d;
          ts_match_q <= ts_equal_d;
          timeout_q  <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end

        S_DONE: begin
          // A new request clears the verdict; captured words stay visible
          // until the new reads overwrite them.
          if (start_i) begin
            state_q     <= S_RD_ID;
            done_q      <= 1'b0;
            id_match_q  <= 1'b0;
            ts_match_q  <= 1'b0;
            timeout_q   <= 1'b0;
            m_read_q    <= 1'b1;
            m_address_q <= 1'b0;
            busy_q      <= 1'b1;
            stall_cnt_q <= 16'd0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          m_read_q    <= 1'b0;
          m_address_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign m_address_o   = m_address_q;
  assign m_read_o      = m_read_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign id_match_o    = id_match_q;
  assign ts_match_o    = ts_match_q;
  assign timeout_o     = timeout_q;
  assign captured_id_o = captured_id_q;
  assign captured_ts_o = captured_ts_q;

endmodule
`default_nettype wire

// File: tb/tb_mysystem_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mysystem_sysid_checker
// Purpose  : Self-checking bench for mysystem_sysid_checker: auto check after
//            reset, a table of read-data patterns, wait states, stall
//            timeout, start while busy, and reset during a stalled read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mysystem_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h8765_4321;
  localparam logic [31:0] EXP_TS = 32'd1766722860;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  // Slave model: two words selected by address.
  logic [31:0] id_word;
  logic [31:0] ts_word;
  assign m_readdata = m_address ? ts_word : id_word;

  int n_cmp = 0;
  int n_bad = 0;

  mysystem_sysid_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(8),
    .AUTO_START    (1'b1)
  ) dut (
    .clock_i        (clock),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .m_address_o    (m_address),
    .m_read_o       (m_read),
    .m_readdata_i   (m_readdata),
    .m_waitrequest_i(m_waitrequest),
    .busy_o         (busy),
    .done_o         (done),
    .id_match_o     (id_match),
    .ts_match_o     (ts_match),
    .timeout_o      (timeout),
    .captured_id_o  (captured_id),
    .captured_ts_o  (captured_ts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        exp_id;
    logic        exp_ts;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1 ({tag, ".m_read"},   m_read,   1'b0);
    chk1 ({tag, ".m_address"},m_address,1'b0);
    chk1 ({tag, ".busy"},     busy,     1'b0);
    chk1 ({tag, ".done"},     done,     1'b0);
    chk1 ({tag, ".id_match"}, id_match, 1'b0);
    chk1 ({tag, ".ts_match"}, ts_match, 1'b0);
    chk1 ({tag, ".timeout"},  timeout,  1'b0);
    chk32({tag, ".cap_id"},   captured_id, 32'd0);
    chk32({tag, ".cap_ts"},   captured_ts, 32'd0);
  endtask

  // Runs the auto check that follows reset release; call in the first cycle
  // with reset_n=1 (state IDLE).
  task automatic auto_check_after_reset(input string tag);
    tick();  // L1: RD_ID
    chk1({tag, ".L1.m_read"}, m_read, 1'b1);
    chk1({tag, ".L1.addr"},   m_address, 1'b0);
    chk1({tag, ".L1.busy"},   busy, 1'b1);
    tick();  // L2: RD_TS
    chk1({tag, ".L2.m_read"}, m_read, 1'b1);
    chk1({tag, ".L2.addr"},   m_address, 1'b1);
    tick();  // L3: CHECK
    chk1({tag, ".L3.m_read"}, m_read, 1'b0);
    chk1({tag, ".L3.busy"},   busy, 1'b1);
    chk1({tag, ".L3.done"},   done, 1'b0);
    tick();  // L4: DONE
    chk1 ({tag, ".L4.done"},    done, 1'b1);
    chk1 ({tag, ".L4.busy"},    busy, 1'b0);
    chk1 ({tag, ".L4.id"},      id_match, 1'b1);
    chk1 ({tag, ".L4.ts"},      ts_match, 1'b1);
    chk1 ({tag, ".L4.timeout"}, timeout, 1'b0);
    chk32({tag, ".L4.cap_id"},  captured_id, EXP_ID);
    chk32({tag, ".L4.cap_ts"},  captured_ts, EXP_TS);
    // Only one automatic check: no further reads without start.
    repeat (3) begin
      tick();
      chk1({tag, ".noauto.m_read"}, m_read, 1'b0);
      chk1({tag, ".noauto.done"},   done, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{EXP_ID,        EXP_TS,        1'b1, 1'b1};
    vecs[1] = '{32'h8765_4320, EXP_TS,        1'b0, 1'b1};
    vecs[2] = '{EXP_ID,        32'd1766722861,1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h0765_4321, EXP_TS,        1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

    reset_n       = 1'b0;
    start         = 1'b0;
    m_waitrequest = 1'b0;
    id_word       = EXP_ID;
    ts_word       = EXP_TS;

    // ---- reset state, then the single automatic check ----
    repeat (3) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;   // L0: IDLE with reset released
    auto_check_after_reset("auto");

    // ---- table of read-data patterns, zero wait states ----
    for (int i = 0; i < 6; i++) begin
      id_word = vecs[i].id_word;
      ts_word = vecs[i].ts_word;
      start = 1'b1;
      tick();         // N+1: RD_ID, verdict cleared
      start = 1'b0;
      chk1($sformatf("vec%0d.N1.done", i),   done, 1'b0);
      chk1($sformatf("vec%0d.N1.busy", i),   busy, 1'b1);
      chk1($sformatf("vec%0d.N1.m_read", i), m_read, 1'b1);
      chk1($sformatf("vec%0d.N1.id", i),     id_match, 1'b0);
      tick(); tick(); tick();  // N+4: DONE
      chk1 ($sformatf("vec%0d.done", i),    done, 1'b1);
      chk1 ($sformatf("vec%0d.id", i),      id_match, vecs[i].exp_id);
      chk1 ($sformatf("vec%0d.ts", i),      ts_match, vecs[i].exp_ts);
      chk1 ($sformatf("vec%0d.timeout", i), timeout, 1'b0);
      chk32($sformatf("vec%0d.cap_id", i),  captured_id, vecs[i].id_word);
      chk32($sformatf("vec%0d.cap_ts", i),  captured_ts, vecs[i].ts_word);
    end

    // ---- three wait states on word 1: done at N+7 ----
    id_word = EXP_ID;
    ts_word = EXP_TS;
    start = 1'b1;
    tick();           // N+1
    start = 1'b0;
    tick();           // N+2: RD_TS
    chk1("ws.N2.m_read", m_read, 1'b1);
    chk1("ws.N2.addr",   m_address, 1'b1);
    m_waitrequest = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk1($sformatf("ws.N%0d.m_read", k), m_read, 1'b1);
      chk1($sformatf("ws.N%0d.addr", k),   m_address, 1'b1);
    end
    m_waitrequest = 1'b0;
    tick();           // N+6: CHECK
    chk1("ws.N6.done",   done, 1'b0);
    chk1("ws.N6.m_read", m_read, 1'b0);
    tick();           // N+7: DONE
    chk1("ws.N7.done", done, 1'b1);
    chk1("ws.N7.id",   id_match, 1'b1);
    chk1("ws.N7.ts",   ts_match, 1'b1);

    // ---- waitrequest stuck high on word 0, TIMEOUT_CYCLES=8 ----
    start = 1'b1;
    tick();           // N+1: RD_ID
    start = 1'b0;
    m_waitrequest = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk1($sformatf("to.N%0d.m_read", k), m_read, 1'b1);
      chk1($sformatf("to.N%0d.addr", k),   m_address, 1'b0);
      chk1($sformatf("to.N%0d.done", k),   done, 1'b0);
    end
    tick();           // N+9: after 8 stalled cycles
    chk1("to.done",    done, 1'b1);
    chk1("to.timeout", timeout, 1'b1);
    chk1("to.m_read",  m_read, 1'b0);
    chk1("to.busy",    busy, 1'b0);
    chk1("to.id",      id_match, 1'b0);
    chk1("to.ts",      ts_match, 1'b0);
    tick();
    chk1("to.hold.m_read",  m_read, 1'b0);
    chk1("to.hold.timeout", timeout, 1'b1);
    m_waitrequest = 1'b0;

    // ---- start during RD_TS ignored; start in DONE re-runs ----
    start = 1'b1;
    tick();           // N+1
    start = 1'b0;
    tick();           // N+2: RD_TS
    chk1("busy.N2.addr", m_address, 1'b1);
    start = 1'b1;
    tick();           // N+3: CHECK
    start = 1'b0;
    chk1("busy.N3.busy",   busy, 1'b1);
    chk1("busy.N3.m_read", m_read, 1'b0);
    tick();           // N+4: DONE
    chk1("busy.N4.done",    done, 1'b1);
    chk1("busy.N4.id",      id_match, 1'b1);
    chk1("busy.N4.ts",      ts_match, 1'b1);
    chk1("busy.N4.timeout", timeout, 1'b0);
    tick();
    chk1("busy.N5.m_read", m_read, 1'b0);
    chk1("busy.N5.done",   done, 1'b1);
    ts_word = 32'h1234_5678;
    start = 1'b1;
    tick();           // RD_ID of re-run
    start = 1'b0;
    chk1 ("rerun.done",   done, 1'b0);
    chk1 ("rerun.id",     id_match, 1'b0);
    chk1 ("rerun.ts",     ts_match, 1'b0);
    chk1 ("rerun.m_read", m_read, 1'b1);
    chk1 ("rerun.addr",   m_address, 1'b0);
    chk32("rerun.kept_ts",captured_ts, EXP_TS);
    tick(); tick(); tick();
    chk1 ("rerun.fin.done", done, 1'b1);
    chk1 ("rerun.fin.id",   id_match, 1'b1);
    chk1 ("rerun.fin.ts",   ts_match, 1'b0);
    chk32("rerun.fin.cap_ts", captured_ts, 32'h1234_5678);

    // ---- reset during a stalled RD_ID ----
    ts_word = EXP_TS;
    start = 1'b1;
    tick();           // N+1: RD_ID
    start = 1'b0;
    m_waitrequest = 1'b1;
    tick();           // N+2: still RD_ID, stalled
    chk1("rstmid.m_read", m_read, 1'b1);
    chk1("rstmid.addr",   m_address, 1'b0);
    reset_n = 1'b0;
    tick();
    chk_all_zero("rstmid");
    reset_n = 1'b1;   // L0
    m_waitrequest = 1'b0;
    auto_check_after_reset("auto2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mysystem_sysid_checker.md
MYSYSTEM_SYSID_CHECKER -- requirements
Module: mysystem_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd2271560481 (0x87654321), SHALL be the system ID value the block expects at sysid word 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1766722860, SHALL be the timestamp value the block expects at sysid word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, SHALL be the maximum number of cycles one read may stall on waitrequest.
REQ-004 Parameter AUTO_START, default 1, SHALL make the block start one check automatically after reset.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-007 start  input  1  single-cycle request to run a check.
REQ-008 m_address  output  1  Avalon-MM master word address to the sysid control slave: 0 = ID, 1 = timestamp.
REQ-009 m_read  output  1  Avalon-MM read strobe.
REQ-010 m_readdata  input  32  read data, valid in the cycle where m_read=1 and m_waitrequest=0.
REQ-011 m_waitrequest  input  1  slave stall; the read is accepted only when it is low.
REQ-012 busy  output  1  high while a check is in progress.
REQ-013 done  output  1  high while a finished result is held.
REQ-014 id_match, ts_match  output  1 each  comparison results.
REQ-015 timeout  output  1  high when the last check was aborted by a stall timeout.
REQ-016 captured_id, captured_ts  output  32 each  raw words read from the slave.

Function
REQ-017 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK and DONE; the block SHALL be busy in RD_ID, RD_TS and CHECK.
REQ-018 In IDLE, start=1 SHALL move the FSM to RD_ID. If AUTO_START=1 and the one-shot flag auto_fired=0, the FSM SHALL also move to RD_ID and set auto_fired.
REQ-019 RD_ID: m_read=1, m_address=0. When m_waitrequest=0, captured_id SHALL be loaded from m_readdata and the FSM SHALL move to RD_TS.
REQ-020 RD_TS: m_read=1, m_address=1. When m_waitrequest=0, captured_ts SHALL be loaded from m_readdata and the FSM SHALL move to CHECK.
REQ-021 m_read SHALL be 0 in IDLE, CHECK and DONE. m_address and m_read SHALL stay stable while m_waitrequest=1.
REQ-022 A 16-bit stall counter SHALL clear on entry to RD_ID or RD_TS and increment on each cycle with m_waitrequest=1.
REQ-023 When the stall counter equals TIMEOUT_CYCLES-1 and m_waitrequest=1, the FSM SHALL go to DONE with timeout=1 and id_match=ts_match=0. m_read SHALL drop in the next cycle.
REQ-024 CHECK (one cycle): id_match SHALL be set to (captured_id==EXPECTED_ID) and ts_match to (captured_ts==EXPECTED_TS), as full 32-bit equality; the FSM SHALL then go to DONE.
REQ-025 DONE: done=1 and all result outputs held. start=1 SHALL clear done, id_match, ts_match and timeout and go to RD_ID in the next cycle; the captured words are kept until they are overwritten.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Latency with zero wait states: start in cycle N -> RD_ID in N+1, RD_TS in N+2, CHECK in N+3, done=1 in N+4.

Reset
REQ-028 With reset_n=0 at a rising edge, the block SHALL go to IDLE and set all of these to 0: m_read, m_address, busy, done, id_match, ts_match, timeout, captured_id, captured_ts, stall counter, auto_fired.
REQ-029 Reset in the middle of a read SHALL drop m_read in the next cycle and discard the check in progress.
REQ-030 After reset_n rises, AUTO_START=1 SHALL give exactly one automatic check; later checks SHALL need start.

Verification
REQ-031 Slave model returns 0x87654321/1766722860 with no wait, AUTO_START=1 -> address sequence 0 then 1, done=1 in the 4th cycle after leaving reset, id_match=1, ts_match=1, timeout=0.
REQ-032 Slave returns 0x87654320 for word 0 -> id_match=0, ts_match=1, captured_id=0x87654320.
REQ-033 Slave holds waitrequest=1 for 3 cycles on word 1 -> m_read and m_address=1 held for 4 cycles, results correct, done at N+7.
REQ-034 waitrequest stuck high, TIMEOUT_CYCLES=8 -> done=1 with timeout=1 after 8 stall cycles, m_read=0 afterwards, id_match=ts_match=0.
REQ-035 start pulsed during RD_TS, then again in DONE -> the first pulse is ignored; the second pulse clears the flags and re-reads both words.
REQ-036 reset_n=0 during RD_ID stall -> all outputs 0 in the next cycle; the auto check repeats once after reset is released.
